// File: rtl/mpu_pkg.sv
// Shared types, opcode constants and the instruction decoder for the mpu_core
// 6502-subset CPU.
package mpu_pkg;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9, OP_LDA_ZP = 8'hA5, OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2, OP_LDX_ZP = 8'hA6, OP_LDX_ABS = 8'hAE;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0, OP_LDY_ZP = 8'hA4, OP_LDY_ABS = 8'hAC;
  localparam logic [7:0] OP_ADC_IMM = 8'h69, OP_ADC_ZP = 8'h65, OP_ADC_ABS = 8'h6D;
  localparam logic [7:0] OP_SBC_IMM = 8'hE9, OP_SBC_ZP = 8'hE5, OP_SBC_ABS = 8'hED;
  localparam logic [7:0] OP_AND_IMM = 8'h29, OP_AND_ZP = 8'h25, OP_AND_ABS = 8'h2D;
  localparam logic [7:0] OP_ORA_IMM = 8'h09, OP_ORA_ZP = 8'h05, OP_ORA_ABS = 8'h0D;
  localparam logic [7:0] OP_EOR_IMM = 8'h49, OP_EOR_ZP = 8'h45, OP_EOR_ABS = 8'h4D;
  localparam logic [7:0] OP_CMP_IMM = 8'hC9, OP_CMP_ZP = 8'hC5, OP_CMP_ABS = 8'hCD;
  localparam logic [7:0] OP_CPX_IMM = 8'hE0, OP_CPX_ZP = 8'hE4, OP_CPX_ABS = 8'hEC;
  localparam logic [7:0] OP_CPY_IMM = 8'hC0, OP_CPY_ZP = 8'hC4, OP_CPY_ABS = 8'hCC;
  localparam logic [7:0] OP_BIT_ZP  = 8'h24, OP_BIT_ABS = 8'h2C;
  localparam logic [7:0] OP_STA_ZP  = 8'h85, OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_STX_ZP  = 8'h86, OP_STX_ABS = 8'h8E;
  localparam logic [7:0] OP_STY_ZP  = 8'h84, OP_STY_ABS = 8'h8C;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_TAX = 8'hAA, OP_TAY = 8'hA8, OP_TXA = 8'h8A, OP_TYA = 8'h98;
  localparam logic [7:0] OP_TSX = 8'hBA, OP_TXS = 8'h9A;
  localparam logic [7:0] OP_INX = 8'hE8, OP_INY = 8'hC8, OP_DEX = 8'hCA, OP_DEY = 8'h88;
  localparam logic [7:0] OP_CLC = 8'h18, OP_SEC = 8'h38, OP_CLI = 8'h58, OP_SEI = 8'h78;
  localparam logic [7:0] OP_CLV = 8'hB8, OP_CLD = 8'hD8, OP_SED = 8'hF8, OP_NOP = 8'hEA;
  localparam logic [7:0] OP_ASL_A = 8'h0A, OP_LSR_A = 8'h4A, OP_ROL_A = 8'h2A, OP_ROR_A = 8'h6A;

  localparam int unsigned FLAG_C = 0, FLAG_Z = 1, FLAG_I = 2, FLAG_D = 3;
  localparam int unsigned FLAG_B = 4, FLAG_V = 6, FLAG_N = 7;

  typedef enum logic [2:0] {RESET0, RESET1, FETCH, OPER_LO, OPER_HI, MEM_RD, MEM_WR} state_t;

  typedef enum logic [3:0] {
    ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_EOR, ALU_ASL,
    ALU_LSR, ALU_ROL, ALU_ROR, ALU_INC, ALU_DEC, ALU_CMP, ALU_BIT
  } alu_op_t;

  typedef enum logic [1:0] {AM_IMP, AM_IMM, AM_ZP, AM_ABS} amode_t;
  typedef enum logic [2:0] {K_NOP, K_EXEC, K_FLAG, K_STORE, K_JMP} kind_t;
  typedef enum logic [2:0] {REG_A, REG_X, REG_Y, REG_S, REG_NONE} reg_t;

  typedef struct packed {
    amode_t     amode;
    kind_t      kind;
    alu_op_t    alu_op;
    reg_t       src;
    reg_t       dst;
    logic       upd_nz;
    logic       upd_c;
    logic       upd_v;
    logic [2:0] flag_idx;
    logic       flag_val;
  } decode_t;

  // Anything not listed falls through as a 2-cycle implied NOP.
  function automatic decode_t decode(input logic [7:0] op);
    decode_t d;
    d.amode    = AM_IMP;
    d.kind     = K_NOP;
    d.alu_op   = ALU_PASS;
    d.src      = REG_A;
    d.dst      = REG_NONE;
    d.upd_nz   = 1'b0;
    d.upd_c    = 1'b0;
    d.upd_v    = 1'b0;
    d.flag_idx = 3'd0;
    d.flag_val = 1'b0;

    case (op)
      OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_ADC_IMM, OP_SBC_IMM, OP_AND_IMM,
      OP_ORA_IMM, OP_EOR_IMM, OP_CMP_IMM, OP_CPX_IMM, OP_CPY_IMM: d.amode = AM_IMM;
      OP_LDA_ZP, OP_LDX_ZP, OP_LDY_ZP, OP_ADC_ZP, OP_SBC_ZP, OP_AND_ZP, OP_ORA_ZP,
      OP_EOR_ZP, OP_CMP_ZP, OP_CPX_ZP, OP_CPY_ZP, OP_BIT_ZP, OP_STA_ZP, OP_STX_ZP,
      OP_STY_ZP: d.amode = AM_ZP;
      OP_LDA_ABS, OP_LDX_ABS, OP_LDY_ABS, OP_ADC_ABS, OP_SBC_ABS, OP_AND_ABS,
      OP_ORA_ABS, OP_EOR_ABS, OP_CMP_ABS, OP_CPX_ABS, OP_CPY_ABS, OP_BIT_ABS,
      OP_STA_ABS, OP_STX_ABS, OP_STY_ABS, OP_JMP_ABS: d.amode = AM_ABS;
      default: ;
    endcase

    case (op)
      OP_LDA_IMM, OP_LDA_ZP, OP_LDA_ABS: begin d.kind = K_EXEC; d.dst = REG_A; d.upd_nz = 1'b1; end
      OP_LDX_IMM, OP_LDX_ZP, OP_LDX_ABS: begin d.kind = K_EXEC; d.dst = REG_X; d.upd_nz = 1'b1; end
      OP_LDY_IMM, OP_LDY_ZP, OP_LDY_ABS: begin d.kind = K_EXEC; d.dst = REG_Y; d.upd_nz = 1'b1; end
      OP_ADC_IMM, OP_ADC_ZP, OP_ADC_ABS: begin
        d.kind = K_EXEC; d.alu_op = ALU_ADD; d.dst = REG_A;
        d.upd_nz = 1'b1; d.upd_c = 1'b1; d.upd_v = 1'b1;
      end
      OP_SBC_IMM, OP_SBC_ZP, OP_SBC_ABS: begin
        d.kind = K_EXEC; d.alu_op = ALU_SUB; d.dst = REG_A;
        d.upd_nz = 1'b1; d.upd_c = 1'b1; d.upd_v = 1'b1;
      end
      OP_AND_IMM, OP_AND_ZP, OP_AND_ABS: begin d.kind = K_EXEC; d.alu_op = ALU_AND; d.dst = REG_A; d.upd_nz = 1'b1; end
      OP_ORA_IMM, OP_ORA_ZP, OP_ORA_ABS: begin d.kind = K_EXEC; d.alu_op = ALU_OR;  d.dst = REG_A; d.upd_nz = 1'b1; end
      OP_EOR_IMM, OP_EOR_ZP, OP_EOR_ABS: begin d.kind = K_EXEC; d.alu_op = ALU_EOR; d.dst = REG_A; d.upd_nz = 1'b1; end
      OP_CMP_IMM, OP_CMP_ZP, OP_CMP_ABS: begin d.kind = K_EXEC; d.alu_op = ALU_CMP; d.upd_nz = 1'b1; d.upd_c = 1'b1; end
      OP_CPX_IMM, OP_CPX_ZP, OP_CPX_ABS: begin
        d.kind = K_EXEC; d.alu_op = ALU_CMP; d.src = REG_X; d.upd_nz = 1'b1; d.upd_c = 1'b1;
      end
      OP_CPY_IMM, OP_CPY_ZP, OP_CPY_ABS: begin
        d.kind = K_EXEC; d.alu_op = ALU_CMP; d.src = REG_Y; d.upd_nz = 1'b1; d.upd_c = 1'b1;
      end
      OP_BIT_ZP, OP_BIT_ABS: begin d.kind = K_EXEC; d.alu_op = ALU_BIT; d.upd_nz = 1'b1; d.upd_v = 1'b1; end
      OP_STA_ZP, OP_STA_ABS: begin d.kind = K_STORE; d.src = REG_A; end
      OP_STX_ZP, OP_STX_ABS: begin d.kind = K_STORE; d.src = REG_X; end
      OP_STY_ZP, OP_STY_ABS: begin d.kind = K_STORE; d.src = REG_Y; end
      OP_JMP_ABS: d.kind = K_JMP;
      OP_TAX: begin d.kind = K_EXEC; d.src = REG_A; d.dst = REG_X; d.upd_nz = 1'b1; end
      OP_TAY: begin d.kind = K_EXEC; d.src = REG_A; d.dst = REG_Y; d.upd_nz = 1'b1; end
      OP_TXA: begin d.kind = K_EXEC; d.src = REG_X; d.dst = REG_A; d.upd_nz = 1'b1; end
      OP_TYA: begin d.kind = K_EXEC; d.src = REG_Y; d.dst = REG_A; d.upd_nz = 1'b1; end
      OP_TSX: begin d.kind = K_EXEC; d.src = REG_S; d.dst = REG_X; d.upd_nz = 1'b1; end
      OP_TXS: begin d.kind = K_EXEC; d.src = REG_X; d.dst = REG_S; end
      OP_INX: begin d.kind = K_EXEC; d.alu_op = ALU_INC; d.src = REG_X; d.dst = REG_X; d.upd_nz = 1'b1; end
      OP_INY: begin d.kind = K_EXEC; d.alu_op = ALU_INC; d.src = REG_Y; d.dst = REG_Y; d.upd_nz = 1'b1; end
      OP_DEX: begin d.kind = K_EXEC; d.alu_op = ALU_DEC; d.src = REG_X; d.dst = REG_X; d.upd_nz = 1'b1; end
      OP_DEY: begin d.kind = K_EXEC; d.alu_op = ALU_DEC; d.src = REG_Y; d.dst = REG_Y; d.upd_nz = 1'b1; end
      OP_ASL_A: begin d.kind = K_EXEC; d.alu_op = ALU_ASL; d.dst = REG_A; d.upd_nz = 1'b1; d.upd_c = 1'b1; end
      OP_LSR_A: begin d.kind = K_EXEC; d.alu_op = ALU_LSR; d.dst = REG_A; d.upd_nz = 1'b1; d.upd_c = 1'b1; end
      OP_ROL_A: begin d.kind = K_EXEC; d.alu_op = ALU_ROL; d.dst = REG_A; d.upd_nz = 1'b1; d.upd_c = 1'b1; end
      OP_ROR_A: begin d.kind = K_EXEC; d.alu_op = ALU_ROR; d.dst = REG_A; d.upd_nz = 1'b1; d.upd_c = 1'b1; end
      OP_CLC: begin d.kind = K_FLAG; d.flag_idx = 3'(FLAG_C); d.flag_val = 1'b0; end
      OP_SEC: begin d.kind = K_FLAG; d.flag_idx = 3'(FLAG_C); d.flag_val = 1'b1; end
      OP_CLI: begin d.kind = K_FLAG; d.flag_idx = 3'(FLAG_I); d.flag_val = 1'b0; end
      OP_SEI: begin d.kind = K_FLAG; d.flag_idx = 3'(FLAG_I); d.flag_val = 1'b1; end
      OP_CLV: begin d.kind = K_FLAG; d.flag_idx = 3'(FLAG_V); d.flag_val = 1'b0; end
      OP_CLD: begin d.kind = K_FLAG; d.flag_idx = 3'(FLAG_D); d.flag_val = 1'b0; end
      OP_SED: begin d.kind = K_FLAG; d.flag_idx = 3'(FLAG_D); d.flag_val = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mpu_if.sv
// CPU-side memory bus: registered address/control from the core, combinational
// read data and the ready strobe from the system.
interface mpu_if;
  logic       RDY;
  logic [7:0] DB_IN;
  logic       R_W;
  logic [7:0] ABL;
  logic [7:0] ABH;
  logic [7:0] DB_OUT;

  modport master (input RDY, DB_IN, output R_W, ABL, ABH, DB_OUT);
  modport slave  (output RDY, DB_IN, input R_W, ABL, ABH, DB_OUT);
endinterface

// File: rtl/mpu_alu.sv
// Combinational 8-bit ALU; binary arithmetic only, flags derived from the result
// except BIT, which reports memory bits 7 and 6.
module mpu_alu
  import mpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  input  alu_op_t    op,
  output logic [7:0] result,
  output logic       n,
  output logic       v,
  output logic       z,
  output logic       c
);

  logic [7:0] b_eff;
  logic       cin_eff;
  logic [8:0] sum;

  always_comb begin
    // Subtract and compare share the adder as a + ~b + carry.
    b_eff   = (op == ALU_SUB || op == ALU_CMP) ? ~b : b;
    cin_eff = (op == ALU_CMP) ? 1'b1 : carry_in;
    sum     = {1'b0, a} + {1'b0, b_eff} + {8'h00, cin_eff};

    // NOTE: every output gets a default before the case so no path infers a latch.
    result = b;
    v      = 1'b0;
    c      = 1'b0;
    unique case (op)
      ALU_ADD, ALU_SUB, ALU_CMP: begin
        result = sum[7:0];
        c      = sum[8];
        v      = (a[7] == b_eff[7]) && (sum[7] != a[7]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_EOR: result = a ^ b;
      ALU_ASL: begin result = {a[6:0], 1'b0};     c = a[7]; end
      ALU_LSR: begin result = {1'b0, a[7:1]};     c = a[0]; end
      ALU_ROL: begin result = {a[6:0], carry_in}; c = a[7]; end
      ALU_ROR: begin result = {carry_in, a[7:1]}; c = a[0]; end
      ALU_INC: result = a + 8'd1;
      ALU_DEC: result = a - 8'd1;
      ALU_BIT: begin result = a & b; v = b[6]; end
      default: result = b;
    endcase

    n = (op == ALU_BIT) ? b[7] : result[7];
    z = (result == 8'h00);
  end

endmodule

// File: rtl/mpu_core.sv
// 6502-subset CPU core: reset-vector fetch, cycle sequencing, decode and register
// file around mpu_alu. One bus cycle per clock; RDY low freezes everything.
module mpu_core
  import mpu_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input logic   CLK,
  input logic   RES,
  mpu_if.master bus
);

  state_t      state, state_n;
  logic [7:0]  a, x, y, s, p, ir, lo;
  logic [7:0]  a_n, x_n, y_n, s_n, p_n, ir_n, lo_n;
  logic [15:0] pc, ab, pc_n, ab_n;
  logic        r_w, r_w_n;
  logic [7:0]  db_out, db_out_n;

  decode_t     dec;
  logic [7:0]  src_val, alu_b, alu_res;
  logic        alu_n, alu_v, alu_z, alu_c;
  logic        exec_cycle;

  assign dec = decode(ir);

  always_comb begin
    unique case (dec.src)
      REG_X:   src_val = x;
      REG_Y:   src_val = y;
      REG_S:   src_val = s;
      default: src_val = a;
    endcase
  end

  // Implied ops feed the source register to both ALU inputs so transfers are PASS.
  assign alu_b = (dec.amode == AM_IMP) ? src_val : bus.DB_IN;

  // The result cycle: second cycle of implied/immediate, or the memory read cycle.
  assign exec_cycle = (state == MEM_RD) ||
                      (state == OPER_LO && (dec.amode == AM_IMP || dec.amode == AM_IMM));

  mpu_alu u_alu (
    .a        (src_val),
    .b        (alu_b),
    .carry_in (p[FLAG_C]),
    .op       (dec.alu_op),
    .result   (alu_res),
    .n        (alu_n),
    .v        (alu_v),
    .z        (alu_z),
    .c        (alu_c)
  );

  always_ff @(posedge CLK) begin
    if (RES)            state <= RESET0;
    else if (bus.RDY)   state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RESET0:  state_n = RESET1;
      RESET1:  state_n = FETCH;
      FETCH:   state_n = OPER_LO;
      OPER_LO: begin
        unique case (dec.amode)
          AM_ZP:   state_n = (dec.kind == K_STORE) ? MEM_WR : MEM_RD;
          AM_ABS:  state_n = OPER_HI;
          default: state_n = FETCH;
        endcase
      end
      OPER_HI: begin
        if (dec.kind == K_JMP)        state_n = FETCH;
        else if (dec.kind == K_STORE) state_n = MEM_WR;
        else                          state_n = MEM_RD;
      end
      MEM_RD, MEM_WR: state_n = FETCH;
      default: state_n = RESET0;
    endcase
  end

  always_comb begin
    a_n = a; x_n = x; y_n = y; s_n = s; p_n = p;
    ir_n = ir; lo_n = lo; pc_n = pc; ab_n = ab;
    r_w_n = r_w; db_out_n = db_out;

    unique case (state)
      RESET0: begin
        lo_n = bus.DB_IN;
        ab_n = RESET_VECTOR + 16'd1;
      end
      RESET1: begin
        pc_n = {bus.DB_IN, lo};
        ab_n = {bus.DB_IN, lo};
      end
      FETCH: begin
        ir_n = bus.DB_IN;
        pc_n = pc + 16'd1;
        ab_n = pc + 16'd1;
      end
      OPER_LO: begin
        unique case (dec.amode)
          AM_IMP: ab_n = pc;
          AM_ZP: begin
            pc_n = pc + 16'd1;
            ab_n = {8'h00, bus.DB_IN};
            if (dec.kind == K_STORE) begin
              r_w_n    = 1'b0;
              db_out_n = src_val;
            end
          end
          AM_ABS: begin
            lo_n = bus.DB_IN;
            pc_n = pc + 16'd1;
            ab_n = pc + 16'd1;
          end
          default: begin
            pc_n = pc + 16'd1;
            ab_n = pc + 16'd1;
          end
        endcase
      end
      OPER_HI: begin
        if (dec.kind == K_JMP) begin
          pc_n = {bus.DB_IN, lo};
          ab_n = {bus.DB_IN, lo};
        end else begin
          pc_n = pc + 16'd1;
          ab_n = {bus.DB_IN, lo};
          if (dec.kind == K_STORE) begin
            r_w_n    = 1'b0;
            db_out_n = src_val;
          end
        end
      end
      MEM_RD: ab_n = pc;
      MEM_WR: begin
        ab_n  = pc;
        r_w_n = 1'b1;
      end
      default: ;
    endcase

    if (exec_cycle) begin
      unique case (dec.kind)
        K_EXEC: begin
          unique case (dec.dst)
            REG_A:   a_n = alu_res;
            REG_X:   x_n = alu_res;
            REG_Y:   y_n = alu_res;
            REG_S:   s_n = alu_res;
            default: ;
          endcase
          if (dec.upd_nz) begin
            p_n[FLAG_N] = alu_n;
            p_n[FLAG_Z] = alu_z;
          end
          if (dec.upd_c) p_n[FLAG_C] = alu_c;
          if (dec.upd_v) p_n[FLAG_V] = alu_v;
        end
        K_FLAG:  p_n[dec.flag_idx] = dec.flag_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (RES) begin
      a      <= 8'h00;
      x      <= 8'h00;
      y      <= 8'h00;
      s      <= 8'hFD;
      p      <= 8'h34;
      ir     <= 8'h00;
      lo     <= 8'h00;
      pc     <= 16'h0000;
      ab     <= RESET_VECTOR;
      r_w    <= 1'b1;
      db_out <= 8'h00;
    end else if (bus.RDY) begin
      a      <= a_n;
      x      <= x_n;
      y      <= y_n;
      s      <= s_n;
      p      <= p_n;
      ir     <= ir_n;
      lo     <= lo_n;
      pc     <= pc_n;
      ab     <= ab_n;
      r_w    <= r_w_n;
      db_out <= db_out_n;
    end
  end

  assign bus.R_W    = r_w;
  assign bus.ABL    = ab[7:0];
  assign bus.ABH    = ab[15:8];
  assign bus.DB_OUT = db_out;

endmodule

// File: tb/tb_mpu_core.sv
// Directed program run on mpu_core against a flat 64 KiB memory model; expected
// register, flag and bus values are worked out by hand for each instruction.
module tb_mpu_core;

  logic CLK = 1'b0;
  logic RES = 1'b1;
  mpu_if bus ();

  logic [7:0] mem [0:65535];
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [7:0] PROG0 [45] = '{
    8'hA9, 8'hFF, 8'hAA, 8'hE8, 8'h8A, 8'hA8,          // 0200 LDA #FF; TAX; INX; TXA; TAY
    8'hA9, 8'h01, 8'h38, 8'h6A,                        // 0206 LDA #01; SEC; ROR A
    8'h38, 8'hA9, 8'h7F, 8'h69, 8'h01,                 // 020A SEC; LDA #7F; ADC #01
    8'hC9, 8'h81,                                      // 020F CMP #81
    8'hA6, 8'h10,                                      // 0211 LDX $10
    8'hA9, 8'hFF,                                      // 0213 LDA #FF
    8'h2D, 8'h34, 8'h12,                               // 0215 AND $1234
    8'h24, 8'h10,                                      // 0218 BIT $10
    8'hB8,                                             // 021A CLV
    8'hA9, 8'h5A, 8'hA2, 8'hA5,                        // 021B LDA #5A; LDX #A5
    8'h8D, 8'h34, 8'h12,                               // 021F STA $1234
    8'h86, 8'h20,                                      // 0222 STX $20
    8'h88, 8'h9A, 8'h0A, 8'h02,                        // 0224 DEY; TXS; ASL A; (undefined)
    8'hE9, 8'h34,                                      // 0228 SBC #34
    8'h4C, 8'h00, 8'h03                                // 022A JMP $0300
  };
  localparam logic [7:0] PROG1 [6] = '{
    8'hAD, 8'h10, 8'h00,                               // 0300 LDA $0010
    8'h8D, 8'h00, 8'h40                                // 0303 STA $4000
  };

  mpu_core #(.RESET_VECTOR(16'hFFFC)) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  assign bus.DB_IN = mem[{bus.ABH, bus.ABL}];

  always @(posedge CLK) begin
    if (bus.R_W == 1'b0) mem[{bus.ABH, bus.ABL}] = bus.DB_OUT;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [15:0] ab_now();
    return {bus.ABH, bus.ABL};
  endfunction

  initial begin
    bus.RDY = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i[15:0]] = 8'h00;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h02;
    mem[16'h0010] = 8'hC3;
    mem[16'h1234] = 8'h3C;
    for (int i = 0; i < 45; i++) mem[16'h0200 + 16'(i)] = PROG0[i];
    for (int i = 0; i < 6; i++)  mem[16'h0300 + 16'(i)] = PROG1[i];

    // Reset and vector fetch
    RES = 1'b1;
    run(2);
    RES = 1'b0;
    check("rst_ab",  ab_now(), 16'hFFFC);
    check("rst_rw",  {15'h0, bus.R_W}, 16'h0001);
    check("rst_dbo", {8'h00, bus.DB_OUT}, 16'h0000);
    check("rst_a",   {8'h00, dut.a}, 16'h0000);
    check("rst_x",   {8'h00, dut.x}, 16'h0000);
    check("rst_y",   {8'h00, dut.y}, 16'h0000);
    check("rst_s",   {8'h00, dut.s}, 16'h00FD);
    check("rst_p",   {8'h00, dut.p}, 16'h0034);
    tick();
    check("vec_hi_ab", ab_now(), 16'hFFFD);
    tick();
    check("fetch_ab", ab_now(), 16'h0200);
    check("fetch_rw", {15'h0, bus.R_W}, 16'h0001);

    // Single-byte transfers and increment wrap
    run(2);
    check("lda_imm_a", {8'h00, dut.a}, 16'h00FF);
    check("lda_imm_n", {15'h0, dut.p[7]}, 16'h0001);
    run(2);
    check("tax_x", {8'h00, dut.x}, 16'h00FF);
    run(6);
    check("inx_wrap_x", {8'h00, dut.x}, 16'h0000);
    check("txa_a",      {8'h00, dut.a}, 16'h0000);
    check("tay_y",      {8'h00, dut.y}, 16'h0000);
    check("tay_p",      {8'h00, dut.p}, 16'h0036);

    // SEC; ROR A with A=$01
    run(6);
    check("ror_a", {8'h00, dut.a}, 16'h0080);
    check("ror_p", {8'h00, dut.p}, 16'h00B5);

    // SEC; LDA #$7F; ADC #$01 -> signed overflow
    run(6);
    check("adc_a", {8'h00, dut.a}, 16'h0081);
    check("adc_p", {8'h00, dut.p}, 16'h00F4);
    run(2);
    check("cmp_a", {8'h00, dut.a}, 16'h0081);
    check("cmp_p", {8'h00, dut.p}, 16'h0077);

    // Memory reads: zero page and absolute
    run(3);
    check("ldx_zp_x", {8'h00, dut.x}, 16'h00C3);
    check("ldx_zp_p", {8'h00, dut.p}, 16'h00F5);
    check("ldx_zp_ab", ab_now(), 16'h0213);
    run(6);
    check("and_abs_a", {8'h00, dut.a}, 16'h003C);
    check("and_abs_p", {8'h00, dut.p}, 16'h0075);
    run(3);
    check("bit_zp_a", {8'h00, dut.a}, 16'h003C);
    check("bit_zp_p", {8'h00, dut.p}, 16'h00F7);
    run(2);
    check("clv_p", {8'h00, dut.p}, 16'h00B7);

    // Stores: R_W low only on the final cycle
    run(4);
    for (int i = 0; i < 4; i++) begin
      check("sta_abs_rw", {15'h0, bus.R_W}, (i == 3) ? 16'h0000 : 16'h0001);
      if (i == 3) begin
        check("sta_abs_ab",  ab_now(), 16'h1234);
        check("sta_abs_dbo", {8'h00, bus.DB_OUT}, 16'h005A);
      end
      tick();
    end
    check("sta_abs_mem", {8'h00, mem[16'h1234]}, 16'h005A);
    check("sta_abs_rw_back", {15'h0, bus.R_W}, 16'h0001);
    check("sta_abs_next", ab_now(), 16'h0222);
    for (int i = 0; i < 3; i++) begin
      check("stx_zp_rw", {15'h0, bus.R_W}, (i == 2) ? 16'h0000 : 16'h0001);
      if (i == 2) check("stx_zp_ab", ab_now(), 16'h0020);
      tick();
    end
    check("stx_zp_mem", {8'h00, mem[16'h0020]}, 16'h00A5);

    // DEY wrap, TXS, ASL, undefined opcode, SBC, JMP
    run(2);
    check("dey_wrap_y", {8'h00, dut.y}, 16'h00FF);
    run(2);
    check("txs_s", {8'h00, dut.s}, 16'h00A5);
    run(2);
    check("asl_a", {8'h00, dut.a}, 16'h00B4);
    check("asl_p", {8'h00, dut.p}, 16'h00B4);
    run(2);
    check("undef_ab", ab_now(), 16'h0228);
    check("undef_a",  {8'h00, dut.a}, 16'h00B4);
    check("undef_p",  {8'h00, dut.p}, 16'h00B4);
    run(2);
    check("sbc_a", {8'h00, dut.a}, 16'h007F);
    check("sbc_p", {8'h00, dut.p}, 16'h0075);
    run(3);
    check("jmp_ab", ab_now(), 16'h0300);

    // RDY low for three cycles in the middle of LDA abs
    run(2);
    check("stall_pre_ab", ab_now(), 16'h0302);
    bus.RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ab", ab_now(), 16'h0302);
      check("stall_pc", dut.pc, 16'h0302);
    end
    bus.RDY = 1'b1;
    run(2);
    check("stall_lda_a",  {8'h00, dut.a}, 16'h00C3);
    check("stall_lda_ab", ab_now(), 16'h0303);

    // Reset in the middle of STA abs, with RDY low to show it is ignored
    run(2);
    RES = 1'b1;
    bus.RDY = 1'b0;
    tick();
    check("rst_mid_ab", ab_now(), 16'hFFFC);
    check("rst_mid_rw", {15'h0, bus.R_W}, 16'h0001);
    check("rst_mid_a",  {8'h00, dut.a}, 16'h0000);
    RES = 1'b0;
    bus.RDY = 1'b1;
    tick();
    check("rst_mid_vec", ab_now(), 16'hFFFD);
    check("rst_mid_nowrite", {8'h00, mem[16'h4000]}, 16'h0000);
    tick();
    check("rst_mid_fetch", ab_now(), 16'h0200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
